// File: rtl/mg_cpa_pipe.sv
// Segmented, pipelined carry-propagate adder with valid/ready stream handshake.
// Optional carry-in port is enabled by defining MG_CPA_PIPE_CIN_EN.
module mg_cpa_pipe #(
    parameter int WIDTH = 14,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef MG_CPA_PIPE_CIN_EN
    input  logic             cin,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int STAGES = (WIDTH + SEG - 1) / SEG;

    logic w_adv;
    logic w_out_vld;

    assign w_out_vld = g_st[STAGES-1].r_vld_p;
    assign w_adv     = ~w_out_vld | out_ready;
    assign in_ready  = w_adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int LO = k * SEG;
        localparam int HI = ((k + 1) * SEG < WIDTH) ? (k + 1) * SEG - 1 : WIDTH - 1;
        localparam int SW = HI - LO + 1;

        logic [WIDTH-1:LO] w_a_in;
        logic [WIDTH-1:LO] w_b_in;
        logic              w_c_in;
        logic              w_v_in;
        logic [SW:0]       w_add;
        logic [HI:0]       w_sum_nx;

        logic [HI:0]       r_sum_p;
        logic              r_c_p;
        logic              r_vld_p;

        if (k == 0) begin : g_head
            assign w_a_in = a;
            assign w_b_in = b;
`ifdef MG_CPA_PIPE_CIN_EN
            assign w_c_in = cin;
`else
            assign w_c_in = 1'b0;
`endif
            assign w_v_in   = in_valid;
            assign w_sum_nx = w_add[SW-1:0];
        end else begin : g_body
            // Upper operand bits arrive skewed by k registers; lower sum bits ride along.
            assign w_a_in   = g_st[k-1].g_fwd.r_a_p;
            assign w_b_in   = g_st[k-1].g_fwd.r_b_p;
            assign w_c_in   = g_st[k-1].r_c_p;
            assign w_v_in   = g_st[k-1].r_vld_p;
            assign w_sum_nx = {w_add[SW-1:0], g_st[k-1].r_sum_p};
        end

        assign w_add = {1'b0, w_a_in[HI:LO]} + {1'b0, w_b_in[HI:LO]} + {{SW{1'b0}}, w_c_in};

        // Stage k boundary: segment sum, carry and valid
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_sum_p <= '0;
                r_c_p   <= 1'b0;
                r_vld_p <= 1'b0;
            end else if (w_adv) begin
                r_sum_p <= w_sum_nx;
                r_c_p   <= w_add[SW];
                r_vld_p <= w_v_in;
            end
        end

        if (HI < WIDTH - 1) begin : g_fwd
            logic [WIDTH-1:HI+1] r_a_p;
            logic [WIDTH-1:HI+1] r_b_p;

            always_ff @(posedge clk) begin
                if (w_adv) begin
                    r_a_p <= w_a_in[WIDTH-1:HI+1];
                    r_b_p <= w_b_in[WIDTH-1:HI+1];
                end
            end
        end
    end

    assign out_valid = w_out_vld;
    assign sum       = g_st[STAGES-1].r_sum_p;
    assign cout      = g_st[STAGES-1].r_c_p;

endmodule

// File: tb/tb_mg_cpa_pipe.sv
// Bench for mg_cpa_pipe: queue-based reference model, directed vectors and a parameter sweep.
module tb_mg_cpa_pipe;
    localparam int WIDTH = 14;
    localparam int SEG   = 4;
    localparam int STG   = 4;
`ifdef MG_CPA_PIPE_CIN_EN
    localparam bit CIN_EN = 1'b1;
`else
    localparam bit CIN_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_ready;
    logic out_valid;
    logic out_ready = 1'b1;
    logic cout;
    logic cin_d = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic [WIDTH-1:0] sum;

    int total = 0;
    int bad = 0;
    longint adv_cnt = 0;
    bit rand_done = 1'b0;

    typedef struct {
        logic [WIDTH:0] val;
        longint         tag;
    } ent_t;
    ent_t q[$];

    always #5 clk = ~clk;

    mg_cpa_pipe #(.WIDTH(WIDTH), .SEG(SEG)) u_dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
`ifdef MG_CPA_PIPE_CIN_EN
        .cin(cin_d),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum(sum),
        .cout(cout)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: a result matures STG advancing edges after its acceptance edge.
    always @(negedge clk) begin
        logic ev;
        logic adv;
        logic cin_eff;
        if (rst) begin
            q.delete();
        end else begin
            ev = (q.size() > 0) && (adv_cnt >= q[0].tag + STG - 1);
            adv = !ev || out_ready;
            chk("out_valid", 32'(out_valid), 32'(ev));
            chk("in_ready", 32'(in_ready), 32'(adv));
            if (ev) begin
                chk("sum", 32'(sum), 32'(q[0].val[WIDTH-1:0]));
                chk("cout", 32'(cout), 32'(q[0].val[WIDTH]));
                if (out_ready) void'(q.pop_front());
            end
            if (adv && in_valid) begin
                cin_eff = CIN_EN & cin_d;
                q.push_back('{val: {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin_eff},
                              tag: adv_cnt + 1});
            end
            if (adv) adv_cnt++;
        end
    end

    // Sweep of other geometries, all sharing one random stream with out_ready tied high.
    logic sw_valid = 1'b0;
    logic sw_cin = 1'b0;
    logic [15:0] sw_a = '0;
    logic [15:0] sw_b = '0;

    for (genvar i = 0; i < 3; i++) begin : g_sw
        localparam int W = (i == 0) ? 16 : ((i == 1) ? 8 : 1);
        localparam int S = (i == 0) ? 16 : ((i == 1) ? 3 : 1);
        localparam int L = (W + S - 1) / S;

        logic o_rdy;
        logic o_v;
        logic o_c;
        logic [W-1:0] o_s;
        logic [W:0] d_val [L];
        logic d_v [L];

        mg_cpa_pipe #(.WIDTH(W), .SEG(S)) u_sw (
            .clk(clk),
            .rst(rst),
            .in_valid(sw_valid),
            .in_ready(o_rdy),
            .a(sw_a[W-1:0]),
            .b(sw_b[W-1:0]),
`ifdef MG_CPA_PIPE_CIN_EN
            .cin(sw_cin),
`endif
            .out_valid(o_v),
            .out_ready(1'b1),
            .sum(o_s),
            .cout(o_c)
        );

        always @(negedge clk) begin
            logic ce;
            if (rst) begin
                for (int k = 0; k < L; k++) d_v[k] = 1'b0;
            end else begin
                chk($sformatf("sw%0d_valid", i), 32'(o_v), 32'(d_v[L-1]));
                chk($sformatf("sw%0d_ready", i), 32'(o_rdy), 32'd1);
                if (d_v[L-1]) begin
                    chk($sformatf("sw%0d_sum", i), 32'(o_s), 32'(d_val[L-1][W-1:0]));
                    chk($sformatf("sw%0d_cout", i), 32'(o_c), 32'(d_val[L-1][W]));
                end
                for (int k = L - 1; k > 0; k--) begin
                    d_v[k] = d_v[k-1];
                    d_val[k] = d_val[k-1];
                end
                ce = CIN_EN & sw_cin;
                d_v[0] = sw_valid;
                d_val[0] = {1'b0, sw_a[W-1:0]} + {1'b0, sw_b[W-1:0]} + {{W{1'b0}}, ce};
            end
        end
    end

    task automatic send(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb, input logic xc);
        int n;
        n = 0;
        in_valid = 1'b1;
        a = xa;
        b = xb;
        cin_d = xc;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 200);
        chk("send_accept", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic single(input string nm, input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                          input logic xc, input logic [WIDTH-1:0] es, input logic ec);
        send(xa, xb, xc);
        repeat (STG - 1) begin
            @(negedge clk);
            chk({nm, "_early"}, 32'(out_valid), 32'd0);
        end
        @(negedge clk);
        chk({nm, "_valid"}, 32'(out_valid), 32'd1);
        chk({nm, "_sum"}, 32'(sum), 32'(es));
        chk({nm, "_cout"}, 32'(cout), 32'(ec));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Carry ripples across every segment boundary.
        single("carry_all", 14'h3FFF, 14'h0001, 1'b0, 14'h0000, 1'b1);

        for (int i = 0; i < 1000; i++)
            send(14'($urandom), 14'($urandom), 1'($urandom));
        repeat (8) @(posedge clk);
        #1;

        out_ready = 1'b0;
        send(14'h1234, 14'h0ABC, 1'b0);
        send(14'h3FFF, 14'h3FFF, 1'b0);
        repeat (2) @(negedge clk);
        repeat (5) begin
            @(negedge clk);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_sum", 32'(sum), 32'h1CF0);
            chk("stall_cout", 32'(cout), 32'd0);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_sum0", 32'(sum), 32'h1CF0);
        @(negedge clk);
        chk("release_valid1", 32'(out_valid), 32'd1);
        chk("release_sum1", 32'(sum), 32'h3FFE);
        chk("release_cout1", 32'(cout), 32'd1);
        @(negedge clk);
        chk("release_empty", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send(14'($urandom), 14'($urandom), 1'($urandom));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        out_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1;

        for (int i = 1; i <= 5; i++)
            send(14'(i), 14'(i), 1'b0);
        #2;
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        chk("pre_rst_sum", 32'(sum), 32'd4);
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_sum", 32'(sum), 32'd0);
        chk("async_rst_cout", 32'(cout), 32'd0);
        chk("async_rst_ready", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        single("post_rst", 14'h0005, 14'h0003, 1'b0, 14'h0008, 1'b0);

`ifdef MG_CPA_PIPE_CIN_EN
        single("cin1", 14'h3FFE, 14'h0001, 1'b1, 14'h0000, 1'b1);
        single("cin0", 14'h3FFE, 14'h0001, 1'b0, 14'h3FFF, 1'b0);
`endif

        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            sw_valid = ($urandom_range(0, 3) != 0);
            sw_a = 16'($urandom);
            sw_b = 16'($urandom);
            sw_cin = 1'($urandom);
        end
        @(posedge clk);
        #1;
        sw_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
